odata_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the top-level odata output stream between NUM internal requesters. It sits directly in front of the odata port of the top module. It grants one requester at a time, holds that grant until the requester's last beat, then rotates priority. Streams use valid/ready/last handshaking.

---
 rtl/odata_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_odata_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odata_rr_arbiter.sv
// odata_rr_arbiter: packet-granular round-robin share of the odata stream among NUM requesters.
// Latency: one arbitration cycle (bubble) per packet, then combinational passthrough of the grant.
// Backpressure: m_ready reaches only the granted requester; optional stall release via ODATA_ARB_TIMEOUT_EN.
module odata_rr_arbiter #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   sys_clock,
    input  logic                   rst_n,
    input  logic [NUM-1:0]         s_valid,
    input  logic [NUM*DSIZE-1:0]   s_data,
    input  logic [NUM-1:0]         s_last,
    output logic [NUM-1:0]         s_ready,
    output logic                   m_valid,
    output logic [DSIZE-1:0]       m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [$clog2(NUM)-1:0] grant_id,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int GW = $clog2(NUM);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    grant_nxt;
    logic [GW-1:0]    sel;
    logic             sel_vld;
    logic             g_valid;
    logic             g_last;
    logic [DSIZE-1:0] g_data;
    logic             xfer;
    logic             force_rel;
    logic [DSIZE-1:0] s_data_a [NUM];

    for (genvar i = 0; i < NUM; i++) begin : g_unpack
        assign s_data_a[i] = s_data[i*DSIZE +: DSIZE];
    end

    assign g_valid = s_valid[grant_id];
    assign g_last  = s_last[grant_id];
    assign g_data  = s_data_a[grant_id];
    assign xfer    = m_valid & m_ready;
    assign busy    = (state == LOCK);

    // First valid requester after the last grant, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = grant_id;
        sel_vld = 1'b0;
        for (int k = 1; k <= NUM; k++) begin
            idx = int'(grant_id) + k;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!sel_vld && s_valid[GW'(idx)]) begin
                sel     = GW'(idx);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        s_ready   = '0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    grant_nxt = sel;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                m_valid           = g_valid;
                m_data            = g_valid ? g_data : '0;
                m_last            = g_valid & g_last;
                s_ready[grant_id] = m_ready;
                if ((xfer && m_last) || force_rel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant_id persists across IDLE so it doubles as the round-robin pointer.
    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= GW'(NUM - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
        end
    end

`ifdef ODATA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_cnt;
    logic          stall_hit;

    // The stall that brings the count to TIMEOUT releases the grant on the same edge.
    assign stall_hit = (state == LOCK) && !g_valid && (stall_cnt == CW'(TIMEOUT - 1));
    assign force_rel = stall_hit;

    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= stall_hit;
            if ((state != LOCK) || xfer) begin
                stall_cnt <= '0;
            end else if (!g_valid) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign force_rel   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_odata_rr_arbiter.sv
// Directed bench for odata_rr_arbiter: fairness, single beat, no preemption, backpressure,
// stall handling (both builds) and asynchronous reset mid-packet.
module tb_odata_rr_arbiter;
    localparam int NUM     = 4;
    localparam int DSIZE   = 8;
    localparam int TIMEOUT = 10;

    logic                 sys_clock = 1'b0;
    logic                 rst_n;
    logic [NUM-1:0]       s_valid;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]       s_last;
    logic [NUM-1:0]       s_ready;
    logic                 m_valid;
    logic [DSIZE-1:0]     m_data;
    logic                 m_last;
    logic                 m_ready;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int bcnt [NUM];
    logic [NUM-1:0] pend;

    always #5 sys_clock = ~sys_clock;

    odata_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)) dut (
        .sys_clock  (sys_clock),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] exp_grant);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mvalid"}, 32'(m_valid), 0);
        chk({tag, "_sready"}, 32'(s_ready), 0);
        chk({tag, "_mdata"}, 32'(m_data), 0);
        chk({tag, "_grant"}, 32'(grant_id), exp_grant);
    endtask

    task automatic set_byte(input int i, input logic [7:0] d);
        s_data[i*DSIZE +: DSIZE] = d;
    endtask

    task automatic drive_all();
        for (int i = 0; i < NUM; i++) begin
            set_byte(i, 8'(16 * i + bcnt[i]));
            s_last[i] = (bcnt[i] == 1);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic mid();
        @(negedge sys_clock);
    endtask

    initial begin
        int g;
        int ph;
        rst_n   = 1'b0;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge sys_clock);
        mid();
        chk_idle("reset", 3);
        chk("reset_mlast", 32'(m_last), 0);
        chk("reset_terr", 32'(timeout_err), 0);

        // All four requesters streaming 2-beat packets.
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < NUM; i++) bcnt[i] = 0;
        s_valid = '1;
        drive_all();
        for (int c = 0; c < 15; c++) begin
            mid();
            ph = c % 3;
            if (ph == 0) begin
                g = (c == 0) ? 3 : ((c / 3) - 1) % 4;
                chk_idle($sformatf("rr_idle%0d", c), 32'(g));
            end else begin
                g = (c / 3) % 4;
                chk($sformatf("rr_grant%0d", c), 32'(grant_id), 32'(g));
                chk($sformatf("rr_busy%0d", c), 32'(busy), 1);
                chk($sformatf("rr_mvalid%0d", c), 32'(m_valid), 1);
                chk($sformatf("rr_mdata%0d", c), 32'(m_data), 32'(16 * g + ph - 1));
                chk($sformatf("rr_mlast%0d", c), 32'(m_last), 32'(ph == 2));
                chk($sformatf("rr_sready%0d", c), 32'(s_ready), 32'(1 << g));
            end
            pend = s_valid & s_ready;
            tick();
            for (int i = 0; i < NUM; i++) begin
                if (pend[i]) bcnt[i] = (bcnt[i] == 1) ? 0 : 1;
            end
            drive_all();
        end

        // Single-beat packet from requester 2.
        s_valid = 4'b0100;
        s_data  = '0;
        set_byte(2, 8'hA5);
        s_last  = 4'b0100;
        mid();
        chk_idle("sb_req", 0);
        tick();
        mid();
        chk("sb_grant", 32'(grant_id), 2);
        chk("sb_mvalid", 32'(m_valid), 1);
        chk("sb_mdata", 32'(m_data), 32'h A5);
        chk("sb_mlast", 32'(m_last), 1);
        chk("sb_sready", 32'(s_ready), 32'b0100);
        tick();
        s_valid = '0;
        s_last  = '0;
        mid();
        chk_idle("sb_done", 2);

        // Requester 1 holds the grant for 4 beats while requester 0 waits.
        tick();
        s_valid = 4'b0010;
        set_byte(1, 8'h21);
        mid();
        chk_idle("np_req", 2);
        tick();
        s_valid = 4'b0011;
        set_byte(0, 8'h0F);
        s_last[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            mid();
            chk($sformatf("np_grant%0d", k), 32'(grant_id), 1);
            chk($sformatf("np_mdata%0d", k), 32'(m_data), 32'(8'h20 + k));
            chk($sformatf("np_mlast%0d", k), 32'(m_last), 32'(k == 4));
            chk($sformatf("np_sready%0d", k), 32'(s_ready), 32'b0010);
            tick();
            if (k < 4) begin
                set_byte(1, 8'(8'h20 + k + 1));
                s_last[1] = (k + 1 == 4);
            end
        end
        s_valid[1] = 1'b0;
        s_last[1]  = 1'b0;
        mid();
        chk_idle("np_gap", 1);
        tick();
        mid();
        chk("np_next_grant", 32'(grant_id), 0);
        chk("np_next_mdata", 32'(m_data), 32'h0F);
        chk("np_next_sready", 32'(s_ready), 32'b0001);
        tick();
        s_valid = '0;
        s_last  = '0;

        // Output backpressure mid-packet.
        s_valid = 4'b1000;
        set_byte(3, 8'h11);
        mid();
        chk_idle("bp_req", 0);
        tick();
        mid();
        chk("bp_grant", 32'(grant_id), 3);
        chk("bp_beat1", 32'(m_data), 32'h11);
        chk("bp_sready1", 32'(s_ready), 32'b1000);
        tick();
        set_byte(3, 8'h3C);
        s_last[3] = 1'b1;
        m_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mid();
            chk($sformatf("bp_hold_mvalid%0d", k), 32'(m_valid), 1);
            chk($sformatf("bp_hold_mdata%0d", k), 32'(m_data), 32'h3C);
            chk($sformatf("bp_hold_sready%0d", k), 32'(s_ready), 0);
            chk($sformatf("bp_hold_busy%0d", k), 32'(busy), 1);
            tick();
        end
        m_ready = 1'b1;
        mid();
        chk("bp_resume_sready", 32'(s_ready), 32'b1000);
        chk("bp_resume_mdata", 32'(m_data), 32'h3C);
        tick();
        s_valid = '0;
        s_last  = '0;
        mid();
        chk_idle("bp_done", 3);

        // Requester 3 stalls mid-packet while requester 0 is pending.
        tick();
        s_valid = 4'b1000;
        set_byte(3, 8'h77);
        mid();
        chk_idle("to_req", 3);
        tick();
        mid();
        chk("to_beat_mdata", 32'(m_data), 32'h77);
        tick();
        s_valid = 4'b0001;
        set_byte(0, 8'h5A);
        s_last  = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            mid();
            chk($sformatf("to_stall_busy%0d", k), 32'(busy), 1);
            chk($sformatf("to_stall_grant%0d", k), 32'(grant_id), 3);
            chk($sformatf("to_stall_mvalid%0d", k), 32'(m_valid), 0);
            chk($sformatf("to_stall_terr%0d", k), 32'(timeout_err), 0);
            tick();
        end
`ifdef ODATA_ARB_TIMEOUT_EN
        mid();
        chk("to_release_busy", 32'(busy), 0);
        chk("to_release_terr", 32'(timeout_err), 1);
        chk("to_release_grant", 32'(grant_id), 3);
        tick();
        mid();
        chk("to_next_terr", 32'(timeout_err), 0);
`else
        mid();
        chk("to_hold_busy", 32'(busy), 1);
        chk("to_hold_terr", 32'(timeout_err), 0);
        chk("to_hold_sready", 32'(s_ready), 32'b1000);
        s_valid[3] = 1'b1;
        set_byte(3, 8'h78);
        s_last[3]  = 1'b1;
        tick();
        s_valid[3] = 1'b0;
        s_last[3]  = 1'b0;
        mid();
        chk("to_end_busy", 32'(busy), 0);
        chk("to_end_terr", 32'(timeout_err), 0);
        tick();
        mid();
`endif
        chk("to_next_grant", 32'(grant_id), 0);
        chk("to_next_mdata", 32'(m_data), 32'h5A);
        chk("to_next_mlast", 32'(m_last), 1);
        tick();
        s_valid = '0;
        s_last  = '0;

        // Asynchronous reset during beat 2 of a 3-beat packet.
        s_valid = 4'b0010;
        set_byte(1, 8'h41);
        mid();
        chk_idle("rst_req", 0);
        tick();
        mid();
        chk("rst_beat1", 32'(m_data), 32'h41);
        tick();
        set_byte(1, 8'h42);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async", 3);
        chk("rst_async_mlast", 32'(m_last), 0);
        chk("rst_async_terr", 32'(timeout_err), 0);
        s_valid = '0;
        tick();
        rst_n   = 1'b1;
        s_valid = 4'b0011;
        set_byte(0, 8'h99);
        s_last  = 4'b0001;
        mid();
        chk_idle("rst_after", 3);
        tick();
        mid();
        chk("rst_first_grant", 32'(grant_id), 0);
        chk("rst_first_mdata", 32'(m_data), 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
